// File: rtl/vc_input_buffer_if.sv
// Handshake bundle for the virtual-channel input buffer: upstream push side,
// downstream pop side and per-VC status.
interface vc_input_buffer_if #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int N_VC   = 4
);
    localparam int VCW = $clog2(N_VC);
    localparam int PW  = $clog2(DEPTH) + 1;

    logic [VCW-1:0]     vc_id_i;
    logic [FLIT_W-1:0]  fdata_i;
    logic               valid_i;
    logic               ready_o;
    logic [VCW-1:0]     vc_sel_i;
    logic [FLIT_W-1:0]  fdata_o;
    logic               valid_o;
    logic               ready_i;
    logic [VCW-1:0]     vc_id_o;
    logic [N_VC*PW-1:0] ocup_o;
    logic [N_VC-1:0]    locked_o;
    logic               err_o;

    modport master (
        output vc_id_i, fdata_i, valid_i, vc_sel_i, ready_i,
        input  ready_o, fdata_o, valid_o, vc_id_o, ocup_o, locked_o, err_o
    );

    modport slave (
        input  vc_id_i, fdata_i, valid_i, vc_sel_i, ready_i,
        output ready_o, fdata_o, valid_o, vc_id_o, ocup_o, locked_o, err_o
    );
endinterface

// File: rtl/vc_input_buffer.sv
// Per-VC circular flit FIFOs with packet locking; one push port steered by
// vc_id_i and one pop port steered by vc_sel_i.
module vc_input_buffer_lane #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int PW     = 3
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_set_lock,
    input  logic              i_clr_lock,
    input  logic [FLIT_W-1:0] i_data,
    output logic [FLIT_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [PW-1:0]     o_ocup,
    output logic              o_locked
);
    localparam int AW = PW - 1;

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              r_locked;
    logic [FLIT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_locked <= 1'b0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_set_lock)      r_locked <= 1'b1;
            else if (i_clr_lock) r_locked <= 1'b0;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_empty  = (r_wptr == r_rptr);
    assign o_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_ocup   = r_wptr - r_rptr;
    assign o_head   = r_mem[r_rptr[AW-1:0]];
    assign o_locked = r_locked;
endmodule

module vc_input_buffer #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4,
    parameter int N_VC   = 4
) (
    input  logic clk,
    input  logic arst,
    vc_input_buffer_if.slave bus
);
    localparam int VCW = $clog2(N_VC);
    localparam int PW  = $clog2(DEPTH) + 1;

    logic [1:0]                   r_rst_sync;
    logic                         r_err;
    logic                         w_live;
    logic [1:0]                   w_type;
    logic                         w_start;
    logic                         w_acc;
    logic                         w_drop;
    logic                         w_uflow;
    logic                         w_pop;
    logic [N_VC-1:0]              w_full;
    logic [N_VC-1:0]              w_empty;
    logic [N_VC-1:0]              w_locked;
    logic [N_VC-1:0][PW-1:0]      w_ocup;
    logic [N_VC-1:0][FLIT_W-1:0]  w_head;

    // Reset assertion is immediate; release is retimed so the first edge after
    // arst rises never sees a push or pop.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_rst_sync <= '0;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_live = r_rst_sync[1];

    assign w_type  = bus.fdata_i[FLIT_W-1 -: 2];
    assign w_start = (w_type == 2'b00) || (w_type == 2'b10);

    assign bus.ready_o = w_live && !w_full[bus.vc_id_i] && !(w_start && w_locked[bus.vc_id_i]);
    assign w_acc       = bus.valid_i && bus.ready_o;
    // Body/tail with no open packet is swallowed: accepted but never stored.
    assign w_drop      = w_acc && w_type[0] && !w_locked[bus.vc_id_i];
    assign w_pop       = w_live && bus.ready_i && !w_empty[bus.vc_sel_i];
    assign w_uflow     = w_live && bus.ready_i && w_empty[bus.vc_sel_i];

    for (genvar k = 0; k < N_VC; k++) begin : g_lane
        logic w_wsel;
        assign w_wsel = (bus.vc_id_i == VCW'(k));

        vc_input_buffer_lane #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PW(PW)) u_lane (
            .clk        (clk),
            .arst       (arst),
            .i_push     (w_acc && !w_drop && w_wsel),
            .i_pop      (w_pop && (bus.vc_sel_i == VCW'(k))),
            .i_set_lock (w_acc && w_wsel && (w_type == 2'b00)),
            .i_clr_lock (w_acc && w_wsel && (w_type == 2'b11)),
            .i_data     (bus.fdata_i),
            .o_head     (w_head[k]),
            .o_full     (w_full[k]),
            .o_empty    (w_empty[k]),
            .o_ocup     (w_ocup[k]),
            .o_locked   (w_locked[k])
        );
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_err <= 1'b0;
        else       r_err <= w_drop || w_uflow;
    end

    assign bus.valid_o  = !w_empty[bus.vc_sel_i];
    assign bus.fdata_o  = bus.valid_o ? w_head[bus.vc_sel_i] : '0;
    assign bus.vc_id_o  = bus.vc_sel_i;
    assign bus.ocup_o   = w_ocup;
    assign bus.locked_o = w_locked;
    assign bus.err_o    = r_err;
endmodule
